// File: rtl/xnor_match_sched_if.sv
// Request/operand/result bundle between compare users and the shared XNOR scheduler.
// The master drives req and operands; the slave returns grant, busy and the result.
// Parameters must match the scheduler instance that uses the slave modport.
interface xnor_match_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CW-1:0]         match_cnt;
  logic                  equal;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, done, done_id, match_cnt, equal
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, done, done_id, match_cnt, equal
  );
endinterface

// File: rtl/xnor_match_sched.sv
// Round-robin shares one 1-bit XNOR stage; streams the winner's operands LSB-first and counts matches.
// Latency: grant edge E0, done pulse after edge E_WIDTH; one operation occupies WIDTH+2 cycles.
// No queuing: requests seen in RUN/DONE are ignored, requester holds req until it sees its gnt.
module xnor_match_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  xnor_match_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);
  // idx must still be at least one bit wide for a 1-bit operand build
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    cur_q, cur_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [CW-1:0]     match_q, match_d;
  logic              equal_q, equal_d;

  logic              found;
  logic [IDW-1:0]    win;
  logic              xbit;
  logic [CW-1:0]     acc_sum;

  // Round-robin search: first set req starting one past the last winner, wrapping
  always_comb begin
    logic [IDW-1:0] cand;
    cand  = '0;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // The shared compare stage: one XNOR bit per cycle folded into the running count
  always_comb begin
    xbit    = ~(a_sh_q[0] ^ b_sh_q[0]);
    acc_sum = acc_q + CW'(xbit);
  end

  // Next-state and registered-output decode; everything holds unless a state acts on it
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    match_d   = match_q;
    equal_d   = equal_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          // operands are captured only here; later a_in/b_in changes are invisible
          ptr_d   = win;
          cur_d   = win;
          a_sh_d  = bus.a_in[win*WIDTH +: WIDTH];
          b_sh_d  = bus.b_in[win*WIDTH +: WIDTH];
          acc_d   = '0;
          idx_d   = '0;
          gnt_d   = NREQ'(1) << win;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          match_d   = acc_sum;
          equal_d   = (acc_sum == CW'(WIDTH));
          done_id_d = cur_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      cur_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      match_q   <= '0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      match_q   <= match_d;
      equal_q   <= equal_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_q;
  assign bus.equal     = equal_q;

endmodule

// File: tb/tb_xnor_match_sched.sv
// Bench for xnor_match_sched: table of single-requester compares, a 1-bit build,
// operand change during RUN, reset abort, all-request rotation and idle hold.
module tb_xnor_match_sched;
  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_n;

  xnor_match_sched_if #(.WIDTH(W), .NREQ(N)) mbus ();
  xnor_match_sched_if #(.WIDTH(1), .NREQ(2)) sbus ();

  xnor_match_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mbus)
  );

  xnor_match_sched #(.WIDTH(1), .NREQ(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  typedef struct {
    logic [1:0] id;
    logic [3:0] cnt;
    logic       eq;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cnt;
    logic       eq;
  } vec_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req_v, $time);
    end
  endtask

  function automatic logic [3:0] model_cnt(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = ~(a ^ b);
    return 4'($countones(x));
  endfunction

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (mbus.gnt == '0 && n < 30);
    if (mbus.gnt == '0) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: got no grant within %0d cycles", n);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (mbus.done == 1'b0 && n < 30);
    if (mbus.done == 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles", n);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mbus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done with id %0d, expected none", mbus.done_id);
        end else begin
          e = sb.pop_front();
          chk("sb_done_id", mbus.done_id, e.id);
          chk("sb_match_cnt", mbus.match_cnt, e.cnt);
          chk("sb_equal", mbus.equal, e.eq);
        end
      end
    end
  end

  initial begin
    vec_t       vt[8];
    exp_t       e;
    int         n;
    logic [7:0] t3a[4];
    logic [7:0] t3b[4];
    int         order[5];
    logic [3:0] last_cnt;

    vt[0] = '{0, 8'hA5, 8'hA5, 4'd8, 1'b1};
    vt[1] = '{0, 8'hF0, 8'hFF, 4'd4, 1'b0};
    vt[2] = '{0, 8'hFF, 8'h00, 4'd0, 1'b0};
    vt[3] = '{1, 8'h0F, 8'h0E, 4'd7, 1'b0};
    vt[4] = '{2, 8'h55, 8'hAA, 4'd0, 1'b0};
    vt[5] = '{3, 8'h81, 8'h80, 4'd7, 1'b0};
    vt[6] = '{3, 8'hC3, 8'hC3, 4'd8, 1'b1};
    vt[7] = '{2, 8'h12, 8'h10, 4'd7, 1'b0};
    order = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    mbus.req  = '0;
    mbus.a_in = '0;
    mbus.b_in = '0;
    sbus.req  = '0;
    sbus.a_in = '0;
    sbus.b_in = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", mbus.gnt, 0);
    chk("rst_busy", mbus.busy, 0);
    chk("rst_done", mbus.done, 0);
    chk("rst_done_id", mbus.done_id, 0);
    chk("rst_match_cnt", mbus.match_cnt, 0);
    chk("rst_equal", mbus.equal, 0);
    rst_n = 1'b1;

    // table of single-requester compares
    for (int i = 0; i < 8; i++) begin
      mbus.a_in = $urandom;
      mbus.b_in = $urandom;
      mbus.a_in[vt[i].id*W +: W] = vt[i].a;
      mbus.b_in[vt[i].id*W +: W] = vt[i].b;
      mbus.req = 4'(1 << vt[i].id);
      e.id  = 2'(vt[i].id);
      e.cnt = vt[i].cnt;
      e.eq  = vt[i].eq;
      sb.push_back(e);
      wait_gnt(n);
      chk("tbl_gnt_wait", n, 1);
      chk("tbl_gnt", mbus.gnt, 1 << vt[i].id);
      chk("tbl_busy", mbus.busy, 1);
      mbus.req = '0;
      wait_done(n);
      chk("tbl_done_latency", n, W);
      @(posedge clk); #1;
      chk("tbl_done_pulse", mbus.done, 0);
      chk("tbl_busy_idle", mbus.busy, 0);
    end

    // 1-bit build: a=1,b=1 on requester 0, then a=1,b=0 on requester 1
    sbus.a_in = 2'b01;
    sbus.b_in = 2'b01;
    sbus.req  = 2'b01;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (sbus.gnt == '0 && n < 10);
    chk("w1_gnt0", sbus.gnt, 2'b01);
    sbus.req = '0;
    @(posedge clk); #1;
    chk("w1_done0", sbus.done, 1);
    chk("w1_cnt0", sbus.match_cnt, 1);
    chk("w1_eq0", sbus.equal, 1);
    chk("w1_id0", sbus.done_id, 0);
    @(posedge clk); #1;
    chk("w1_done_drop", sbus.done, 0);
    sbus.a_in = 2'b10;
    sbus.b_in = 2'b00;
    sbus.req  = 2'b10;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (sbus.gnt == '0 && n < 10);
    chk("w1_gnt1", sbus.gnt, 2'b10);
    sbus.req = '0;
    @(posedge clk); #1;
    chk("w1_done1", sbus.done, 1);
    chk("w1_cnt1", sbus.match_cnt, 0);
    chk("w1_eq1", sbus.equal, 0);
    chk("w1_id1", sbus.done_id, 1);
    @(posedge clk); #1;

    // operands change during RUN and req2 arrives mid-operation
    mbus.a_in[1*W +: W] = 8'h3C;
    mbus.b_in[1*W +: W] = 8'h3C;
    mbus.req = 4'b0010;
    e = '{2'd1, 4'd8, 1'b1};
    sb.push_back(e);
    wait_gnt(n);
    chk("t4_gnt1", mbus.gnt, 4'b0010);
    mbus.req = '0;
    @(posedge clk); #1;
    chk("t4_gnt_pulse", mbus.gnt, 0);
    mbus.a_in[1*W +: W] = 8'h00;
    mbus.b_in[1*W +: W] = 8'hFF;
    mbus.a_in[2*W +: W] = 8'h77;
    mbus.b_in[2*W +: W] = 8'h75;
    mbus.req = 4'b0100;
    e = '{2'd2, 4'd7, 1'b0};
    sb.push_back(e);
    wait_gnt(n);
    chk("t4_regrant_gap", n, W + 1);
    chk("t4_gnt2", mbus.gnt, 4'b0100);
    mbus.req = '0;
    wait_done(n);
    @(posedge clk); #1;

    // reset at idx=3 of RUN aborts the operation
    mbus.a_in[0 +: W] = 8'h00;
    mbus.b_in[0 +: W] = 8'h00;
    mbus.req = 4'b0001;
    wait_gnt(n);
    chk("t5_gnt", mbus.gnt, 4'b0001);
    mbus.req = '0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t5_gnt0", mbus.gnt, 0);
    chk("t5_busy0", mbus.busy, 0);
    chk("t5_done0", mbus.done, 0);
    chk("t5_done_id0", mbus.done_id, 0);
    chk("t5_match_cnt0", mbus.match_cnt, 0);
    chk("t5_equal0", mbus.equal, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all requests held: rotation 0,1,2,3,0 with WIDTH+2 spacing
    for (int s = 0; s < 4; s++) begin
      t3a[s] = 8'($urandom);
      t3b[s] = 8'($urandom);
      mbus.a_in[s*W +: W] = t3a[s];
      mbus.b_in[s*W +: W] = t3b[s];
    end
    mbus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e.id  = 2'(order[k]);
      e.cnt = model_cnt(t3a[order[k]], t3b[order[k]]);
      e.eq  = (e.cnt == 4'd8);
      sb.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      if (k == 0) chk("t3_first_wait", n, 1);
      else        chk("t3_spacing", n, W + 2);
      chk("t3_order", mbus.gnt, 1 << order[k]);
    end
    mbus.req = '0;
    wait_done(n);
    @(posedge clk); #1;
    last_cnt = model_cnt(t3a[0], t3b[0]);

    // idle: nothing moves, last result holds
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("t6_busy", mbus.busy, 0);
      chk("t6_gnt", mbus.gnt, 0);
      chk("t6_done", mbus.done, 0);
      chk("t6_match_cnt", mbus.match_cnt, last_cnt);
      chk("t6_done_id", mbus.done_id, 0);
      chk("t6_equal", mbus.equal, last_cnt == 4'd8);
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
